// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures high, low and period lengths of an asynchronous divided clock
// Counts are in clk_in cycles; one result is latched per complete rise->fall->rise of sig_in.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             meas_valid,
  output logic             sat,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W-1:0]       lcnt;
  logic                   h_ovf;
  logic                   l_ovf;
  logic                   s;
  logic                   rise;
  logic                   fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // The synchronizer runs regardless of en so edges are clean when measurement resumes.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      h_ovf      <= 1'b0;
      l_ovf      <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      sat        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
        hcnt  <= '0;
        lcnt  <= '0;
        h_ovf <= 1'b0;
        l_ovf <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              hcnt  <= CNT_W'(1);
              h_ovf <= 1'b0;
              state <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              lcnt  <= CNT_W'(1);
              l_ovf <= 1'b0;
              state <= LOW;
            end else if (hcnt == TO_VAL && !rise) begin
              timeout <= 1'b1;
              hcnt    <= '0;
              lcnt    <= '0;
              state   <= IDLE;
            end else if (hcnt == CNT_MAX) begin
              h_ovf <= 1'b1;
            end else begin
              hcnt <= hcnt + CNT_W'(1);
            end
          end
          LOW: begin
            if (rise) begin
              high_cnt   <= hcnt;
              low_cnt    <= lcnt;
              period_cnt <= {1'b0, hcnt} + {1'b0, lcnt};
              sat        <= h_ovf | l_ovf;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              hcnt       <= CNT_W'(1);
              h_ovf      <= 1'b0;
              state      <= HIGH;
            end else if (lcnt == TO_VAL && !fall) begin
              timeout <= 1'b1;
              hcnt    <= '0;
              lcnt    <= '0;
              state   <= IDLE;
            end else if (lcnt == CNT_MAX) begin
              l_ovf <= 1'b1;
            end else begin
              lcnt <= lcnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - table-driven scoreboard bench for clk_period_meter
module tb_clk_period_meter;

  localparam int LAT = 3;

  typedef struct {
    int hc;
    int lc;
    int pc;
    int s;
    int cyc;
  } exp_t;

  typedef struct {
    int dut;
    int h;
    int l;
    int n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic        sig = 1'b0;
  logic [15:0] hc_a, lc_a;
  logic [16:0] pc_a;
  logic        mv_a, sat_a, to_a;
  logic [3:0]  hc_b, lc_b;
  logic [4:0]  pc_b;
  logic        mv_b, sat_b, to_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cur = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[7];

  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(20)) dut_a (
    .clk_in(clk), .rst_n(rst_n), .en(en_a), .sig_in(sig),
    .high_cnt(hc_a), .low_cnt(lc_a), .period_cnt(pc_a),
    .meas_valid(mv_a), .sat(sat_a), .timeout(to_a)
  );

  clk_period_meter #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(15)) dut_b (
    .clk_in(clk), .rst_n(rst_n), .en(en_b), .sig_in(sig),
    .high_cnt(hc_b), .low_cnt(lc_b), .period_cnt(pc_b),
    .meas_valid(mv_b), .sat(sat_b), .timeout(to_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_pulse(input int id, input int hc, input int lc, input int pc,
                             input int s, input int to);
    exp_t e;
    bit   empty;
    empty = (id == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse dut%0d: got meas_valid=1 at cycle %0d, required none", id, cyc);
    end else begin
      if (id == 0) e = q_a.pop_front();
      else         e = q_b.pop_front();
      chk("high_cnt", hc, e.hc);
      chk("low_cnt", lc, e.lc);
      chk("period_cnt", pc, e.pc);
      chk("sat", s, e.s);
      chk("timeout_on_valid", to, 0);
      chk("pulse_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mv_a) check_pulse(0, int'(hc_a), int'(lc_a), int'(pc_a), int'(sat_a), int'(to_a));
    if (mv_b) check_pulse(1, int'(hc_b), int'(lc_b), int'(pc_b), int'(sat_b), int'(to_b));
  end

  // Drive sig for n captured cycles; a pushed phase is the closing rise of a period.
  task automatic phase(input logic v, input int n, input bit push, input int eh, input int el);
    exp_t e;
    @(negedge clk);
    sig = v;
    if (push) begin
      e = '{eh, el, eh + el, 0, cyc + LAT};
      if (cur == 0) q_a.push_back(e);
      else          q_b.push_back(e);
    end
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    en_a = 1'b0;
    en_b = 1'b0;
    sig  = 1'b0;
    repeat (4) @(negedge clk);
    en_a = (cur == 0);
    en_b = (cur == 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q_a.size() + q_b.size()) != 0; i++) @(negedge clk);
    chk("drain_pending", q_a.size() + q_b.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    cur = v.dut;
    restart();
    phase(1'b1, v.h, 1'b0, 0, 0);
    phase(1'b0, v.l, 1'b0, 0, 0);
    for (int i = 0; i < v.n; i++) begin
      phase(1'b1, v.h, 1'b1, v.h, v.l);
      phase(1'b0, (i == v.n - 1) ? 2 : v.l, 1'b0, 0, 0);
    end
    drain();
  endtask

  initial begin
    vecs[0] = '{0, 4, 3, 3};
    vecs[1] = '{0, 2, 2, 4};
    vecs[2] = '{0, 5, 5, 2};
    vecs[3] = '{0, 7, 2, 2};
    vecs[4] = '{0, 3, 6, 2};
    vecs[5] = '{1, 14, 14, 1};
    vecs[6] = '{1, 15, 15, 1};

    repeat (2) @(negedge clk);
    chk("reset_high_cnt", int'(hc_a), 0);
    chk("reset_low_cnt", int'(lc_a), 0);
    chk("reset_period_cnt", int'(pc_a), 0);
    chk("reset_meas_valid", int'(mv_a), 0);
    chk("reset_sat", int'(sat_a), 0);
    chk("reset_timeout", int'(to_a), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    chk("b_timeout_clear", int'(to_b), 0);

    // en dropped mid-HIGH: no result until a whole new period
    cur = 0;
    restart();
    phase(1'b1, 3, 1'b0, 0, 0);
    @(negedge clk);
    en_a = 1'b0;
    repeat (10) @(negedge clk);
    en_a = 1'b1;
    phase(1'b1, 2, 1'b0, 0, 0);
    phase(1'b0, 3, 1'b0, 0, 0);
    phase(1'b1, 4, 1'b0, 0, 0);
    phase(1'b0, 3, 1'b0, 0, 0);
    phase(1'b1, 4, 1'b1, 4, 3);
    phase(1'b0, 2, 1'b0, 0, 0);
    drain();

    // timeout after 20 counted low cycles, then recovery
    restart();
    phase(1'b1, 5, 1'b0, 0, 0);
    phase(1'b0, 5, 1'b0, 0, 0);
    phase(1'b1, 5, 1'b1, 5, 5);
    @(negedge clk);
    sig = 1'b0;
    repeat (22) @(negedge clk);
    chk("timeout_before_limit", int'(to_a), 0);
    @(negedge clk);
    chk("timeout_at_limit", int'(to_a), 1);
    chk("timeout_hold_high", int'(hc_a), 5);
    chk("timeout_hold_low", int'(lc_a), 5);
    chk("timeout_hold_period", int'(pc_a), 10);
    repeat (5) @(negedge clk);
    phase(1'b1, 5, 1'b0, 0, 0);
    phase(1'b0, 5, 1'b0, 0, 0);
    chk("timeout_sticky", int'(to_a), 1);
    phase(1'b1, 5, 1'b1, 5, 5);
    phase(1'b0, 2, 1'b0, 0, 0);
    drain();
    chk("timeout_cleared", int'(to_a), 0);

    // asynchronous reset mid-LOW
    restart();
    phase(1'b1, 4, 1'b0, 0, 0);
    phase(1'b0, 3, 1'b0, 0, 0);
    phase(1'b1, 4, 1'b1, 4, 3);
    @(negedge clk);
    sig = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_high_cnt", int'(hc_a), 0);
    chk("areset_low_cnt", int'(lc_a), 0);
    chk("areset_period_cnt", int'(pc_a), 0);
    chk("areset_meas_valid", int'(mv_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    phase(1'b1, 4, 1'b0, 0, 0);
    phase(1'b0, 3, 1'b0, 0, 0);
    phase(1'b1, 4, 1'b1, 4, 3);
    phase(1'b0, 3, 1'b0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures the divided clock produced by the frequency-divider stage, directly downstream of it.
- Samples that signal in the clk_in domain and reports high time, low time and period, each in clk_in cycles, once per input period.
- Flags stalled inputs (timeout) and counter saturation.
- Used to check the divide ratio and duty cycle of the odd and even dividers in hardware.

Parameters:
CNT_W, 16, width of the high/low counters and of high_cnt/low_cnt
SYNC_STAGES, 2, synchronizer flops on sig_in (minimum 2)
TIMEOUT, 1023, phase-length limit in clk_in cycles; reaching it aborts the measurement (must be < 2^CNT_W)

Ports:
clk_in     input   1        measurement clock, rising edge
rst_n      input   1        asynchronous active-low reset
en         input   1        measurement enable
sig_in     input   1        divided clock under test, asynchronous to clk_in
high_cnt   output  CNT_W    latched high-phase length
low_cnt    output  CNT_W    latched low-phase length
period_cnt output  CNT_W+1  latched high_cnt+low_cnt
meas_valid output  1        one-cycle pulse when a new result is latched
sat        output  1        latched result contains a saturated counter
timeout    output  1        sticky: no edge seen within TIMEOUT cycles

Behaviour:
- Reset (asynchronous, active-low): all outputs are 0, the synchronizer and edge flops are 0, hcnt=lcnt=0, FSM is IDLE.
- Synchronizer: a chain of SYNC_STAGES flops; s is the last stage and s_d is s delayed by one flop.
  - rise = s & ~s_d; fall = ~s & s_d.
  - A sig_in rise captured at clk edge k appears as rise after edge k+SYNC_STAGES-1; the FSM acts on edge k+SYNC_STAGES.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise, hcnt<=1 and go to HIGH. A fall is ignored.
  - HIGH: on fall, lcnt<=1 and go to LOW; hcnt is not incremented on that edge. Otherwise hcnt increments, saturating at 2^CNT_W-1.
  - LOW: on rise:
    - latch high_cnt<=hcnt, low_cnt<=lcnt, period_cnt<=hcnt+lcnt (CNT_W+1 bits, no overflow);
    - sat<=(hcnt or lcnt saturated); meas_valid<=1 for one cycle; timeout<=0;
    - hcnt<=1 and go to HIGH.
  - LOW, no rise: lcnt increments, saturating.
- The first result requires a complete rise->fall->rise sequence after IDLE. No partial period is ever reported.
- Latency: meas_valid is high in the cycle after edge k+SYNC_STAGES, where k is the edge that captured the closing sig_in rise.
- Timeout: in HIGH or LOW, if the active counter equals TIMEOUT and no edge is detected this cycle:
  - timeout<=1 (sticky), go to IDLE, clear hcnt and lcnt;
  - high_cnt, low_cnt, period_cnt and sat hold their previous values.
  - timeout clears only on the next meas_valid or on reset.
- Simultaneous events: an edge detected in the same cycle the limit is reached is processed normally, with no timeout. Saturation is unreachable when TIMEOUT < 2^CNT_W, but sat is still implemented.
- en=0: the FSM is forced to IDLE, hcnt and lcnt are cleared, and meas_valid is 0. Latched outputs and timeout hold. The synchronizer keeps running.
- en rising: measurement restarts from IDLE. The next rise starts a new period.
- Reset mid-measurement: returns immediately to the reset state. No pulse is emitted.
- meas_valid is never high for two consecutive cycles. The minimum spacing equals the input period, which must be ≥ 2 cycles per phase.

Test Plan:
- Reset, en=1, drive sig_in synchronous to clk_in, 4 cycles high / 3 low (divide-by-7), repeated -> first meas_valid after the second rise: high_cnt=4, low_cnt=3, period_cnt=7, sat=0. Then one pulse every 7 cycles.
- sig_in 2 high / 2 low -> high_cnt=2, low_cnt=2, period_cnt=4 each period; meas_valid pulses every 4 cycles.
- Hold sig_in low after one full period, TIMEOUT=20 -> timeout=1 exactly 20 counted low cycles after the phase start. Previous results hold. Restart a 5/5 pattern -> timeout=0 on meas_valid with period_cnt=10.
- Drop en for 10 cycles mid-HIGH, then re-enable -> no meas_valid until a complete new period. That result equals the true pattern, with no count carried over.
- Assert rst_n=0 mid-LOW -> all outputs 0 immediately (asynchronous). After release, the first meas_valid requires a full period.
- CNT_W=4, TIMEOUT=15, sig_in high 14 / low 14 -> high_cnt=14, low_cnt=14, period_cnt=28 (5-bit), sat=0. Edge and limit coincident at 15 -> no timeout, measurement latched.
